// File: rtl/brew_pkg_1058.sv
// Shared types and default timing constants for the brewing unit.
package brew_pkg_1058;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRIND = 3'd1,
        HEAT  = 3'd2,
        POUR  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } brew_state_t;

    localparam int CNT_W_DEF        = 16;
    localparam int GRIND_CYC_DEF    = 4000;
    localparam int HEAT_MAX_CYC_DEF = 40000;
    localparam int POUR_CYC_DEF     = 20000;

endpackage

// File: rtl/brew_timer_1058.sv
// Loadable down-counter used as the phase timer. It saturates at zero.
module brew_timer_1058 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Counter register: load takes priority over decrement; zero never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/brew_unit_1058.sv
// Brewing-unit sequencer: answers the prepare_coffee/coffee_ready handshake
// by running grinder, heater and pump for timed phases, with abort and fault
// handling. Outputs are registered decodes of the next state, so they always
// match the current state (Moore behaviour).
module brew_unit_1058
    import brew_pkg_1058::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int GRIND_CYC    = GRIND_CYC_DEF,
    parameter int HEAT_MAX_CYC = HEAT_MAX_CYC_DEF,
    parameter int POUR_CYC     = POUR_CYC_DEF
) (
    input  logic clk4m,
    input  logic rst,
    input  logic prepare_coffee,
    input  logic temp_ok,
    input  logic water_low,
    output logic grinder_on,
    output logic heater_on,
    output logic pump_on,
    output logic coffee_ready,
    output logic brew_fault
);

    localparam logic [CNT_W-1:0] GRIND_LOAD = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] HEAT_LOAD  = CNT_W'(HEAT_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] POUR_LOAD  = CNT_W'(POUR_CYC - 1);

    brew_state_t      r_state;
    brew_state_t      w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;
    logic             r_grinder_on;
    logic             r_heater_on;
    logic             r_pump_on;
    logic             r_coffee_ready;
    logic             r_brew_fault;

    brew_timer_1058 #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk4m),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk4m) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and timer control; abort beats water fault beats progress.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = {CNT_W{1'b0}};
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (prepare_coffee && !water_low) begin
                    w_next     = GRIND;
                    w_load     = 1'b1;
                    w_load_val = GRIND_LOAD;
                end else if (prepare_coffee) begin
                    w_next = FAULT;
                end else begin
                    w_next = IDLE;
                end
            end
            GRIND: begin
                if (!prepare_coffee) begin
                    w_next = IDLE;
                end else if (water_low) begin
                    w_next = FAULT;
                end else if (w_zero) begin
                    w_next     = HEAT;
                    w_load     = 1'b1;
                    w_load_val = HEAT_LOAD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            HEAT: begin
                if (!prepare_coffee) begin
                    w_next = IDLE;
                end else if (water_low) begin
                    w_next = FAULT;
                end else if (temp_ok) begin
                    w_next     = POUR;
                    w_load     = 1'b1;
                    w_load_val = POUR_LOAD;
                end else if (w_zero) begin
                    w_next = FAULT;
                end else begin
                    w_dec = 1'b1;
                end
            end
            POUR: begin
                if (!prepare_coffee) begin
                    w_next = IDLE;
                end else if (water_low) begin
                    w_next = FAULT;
                end else if (w_zero) begin
                    w_next = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                if (!prepare_coffee) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            FAULT: begin
                if (!prepare_coffee && !water_low) begin
                    w_next = IDLE;
                end else begin
                    w_next = FAULT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output registers decoded from the state being entered.
    always_ff @(posedge clk4m) begin
        if (rst) begin
            r_grinder_on   <= 1'b0;
            r_heater_on    <= 1'b0;
            r_pump_on      <= 1'b0;
            r_coffee_ready <= 1'b0;
            r_brew_fault   <= 1'b0;
        end else begin
            r_grinder_on   <= (w_next == GRIND);
            r_heater_on    <= (w_next == HEAT) || (w_next == POUR);
            r_pump_on      <= (w_next == POUR);
            r_coffee_ready <= (w_next == DONE);
            r_brew_fault   <= (w_next == FAULT);
        end
    end

    assign grinder_on   = r_grinder_on;
    assign heater_on    = r_heater_on;
    assign pump_on      = r_pump_on;
    assign coffee_ready = r_coffee_ready;
    assign brew_fault   = r_brew_fault;

endmodule

// File: tb/tb_brew_unit_1058.sv
// Scoreboard bench for brew_unit_1058: a phase/elapsed-time reference model
// predicts each cycle's outputs into a queue; a negedge monitor compares.
module tb_brew_unit_1058;

    localparam int CNT_W        = 8;
    localparam int GRIND_CYC    = 4;
    localparam int HEAT_MAX_CYC = 10;
    localparam int POUR_CYC     = 6;

    localparam int P_IDLE  = 0;
    localparam int P_GRIND = 1;
    localparam int P_HEAT  = 2;
    localparam int P_POUR  = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    logic clk = 1'b0;
    logic rst;
    logic prepare_coffee;
    logic temp_ok;
    logic water_low;
    logic grinder_on;
    logic heater_on;
    logic pump_on;
    logic coffee_ready;
    logic brew_fault;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    int m_phase   = P_IDLE;
    int m_elapsed = 0;

    brew_unit_1058 #(
        .CNT_W        (CNT_W),
        .GRIND_CYC    (GRIND_CYC),
        .HEAT_MAX_CYC (HEAT_MAX_CYC),
        .POUR_CYC     (POUR_CYC)
    ) dut (
        .clk4m          (clk),
        .rst            (rst),
        .prepare_coffee (prepare_coffee),
        .temp_ok        (temp_ok),
        .water_low      (water_low),
        .grinder_on     (grinder_on),
        .heater_on      (heater_on),
        .pump_on        (pump_on),
        .coffee_ready   (coffee_ready),
        .brew_fault     (brew_fault)
    );

    always #5 clk = ~clk;

    // Expected {grinder, heater, pump, ready, fault} for a phase.
    function automatic logic [4:0] phase_outputs(input int ph);
        logic [4:0] v;
        v = 5'b00000;
        if (ph == P_GRIND) v[4] = 1'b1;
        if (ph == P_HEAT || ph == P_POUR) v[3] = 1'b1;
        if (ph == P_POUR) v[2] = 1'b1;
        if (ph == P_DONE) v[1] = 1'b1;
        if (ph == P_FAULT) v[0] = 1'b1;
        return v;
    endfunction

    // Reference model: phase plus cycles already spent in it.
    always @(posedge clk) begin
        int np;
        np = m_phase;
        if (rst) begin
            np = P_IDLE;
        end else if ((m_phase == P_GRIND || m_phase == P_HEAT || m_phase == P_POUR) && !prepare_coffee) begin
            np = P_IDLE;
        end else if ((m_phase == P_GRIND || m_phase == P_HEAT || m_phase == P_POUR) && water_low) begin
            np = P_FAULT;
        end else begin
            case (m_phase)
                P_IDLE:  if (prepare_coffee) np = water_low ? P_FAULT : P_GRIND;
                P_GRIND: if (m_elapsed + 1 >= GRIND_CYC) np = P_HEAT;
                P_HEAT:  if (temp_ok) np = P_POUR;
                         else if (m_elapsed + 1 >= HEAT_MAX_CYC) np = P_FAULT;
                P_POUR:  if (m_elapsed + 1 >= POUR_CYC) np = P_DONE;
                P_DONE:  if (!prepare_coffee) np = P_IDLE;
                P_FAULT: if (!prepare_coffee && !water_low) np = P_IDLE;
                default: np = P_IDLE;
            endcase
        end
        if (np != m_phase || rst) m_elapsed = 0;
        else m_elapsed = m_elapsed + 1;
        m_phase = np;
        exp_q.push_back(phase_outputs(np));
    end

    // Monitor: compare DUT outputs with the oldest prediction.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {grinder_on, heater_on, pump_on, coffee_ready, brew_fault};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got g/h/p/r/f=%b expected=%b", $time, g, e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; prepare_coffee = 1'b0; temp_ok = 1'b0; water_low = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // 1: normal brew with explicit coffee_ready latency
        temp_ok = 1'b1; prepare_coffee = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (coffee_ready) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 12) begin
            failures++;
            $display("FAIL ready_latency got=%0d edges (seen=%0d) expected=12", n, seen);
        end
        cyc(2); prepare_coffee = 1'b0; cyc(3);

        // 2: slow heater -> fault after 10 heat cycles
        temp_ok = 1'b0; prepare_coffee = 1'b1; cyc(18);
        prepare_coffee = 1'b0; cyc(3);

        // 3: water low at request
        water_low = 1'b1; prepare_coffee = 1'b1; cyc(4);
        prepare_coffee = 1'b0; cyc(3);
        water_low = 1'b0; cyc(3);

        // 4a: water low mid-pour -> fault
        temp_ok = 1'b1; prepare_coffee = 1'b1; cyc(8);
        water_low = 1'b1; cyc(1); water_low = 1'b0; cyc(2);
        prepare_coffee = 1'b0; cyc(3);
        // 4b: water low together with release -> idle
        prepare_coffee = 1'b1; cyc(8);
        water_low = 1'b1; prepare_coffee = 1'b0; cyc(1);
        water_low = 1'b0; cyc(3);

        // 5: abort in grind cycle 2, then full re-request
        prepare_coffee = 1'b1; cyc(2);
        prepare_coffee = 1'b0; cyc(2);
        prepare_coffee = 1'b1; cyc(16);
        prepare_coffee = 1'b0; cyc(3);

        // 6: reset in pour, brew restarts after release
        prepare_coffee = 1'b1; cyc(8);
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(16);
        prepare_coffee = 1'b0; cyc(3);

        // Random phase: slowly varying levels, occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) prepare_coffee = ~prepare_coffee;
            if ($urandom_range(0, 39) == 0) water_low = ~water_low;
            temp_ok = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0; prepare_coffee = 1'b0; water_low = 1'b0;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
